led_message_scroller: RTL and testbench

//  Controller that sequences the four-digit LED driver from received UART bytes.
//  - Buffers incoming bytes as hex nibbles in a circular message store.
//  - Scrolls a 4-digit window across the message at a programmable rate.
//  - Presents the window as the 16-bit data word consumed by the LED driver.
//  - Sits between the UART receiver and the LED driver; owns all display content policy.

---
 rtl/led_message_scroller.sv | 177 +++++++++++++++++
 tb/tb_led_message_scroller.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/led_message_scroller.sv
// rtl/led_message_scroller.sv - scrolls a 4-digit window across a UART-fed circular nibble store
// Define LED_SCROLL_PINGPONG_EN for back-and-forth scrolling instead of wrap-around.
module led_message_scroller #(
  parameter int MSG_NIBBLES = 16,
  parameter int SCROLL_DIV  = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_perror,
  input  logic        rx_ferror,
  input  logic        clear,
  input  logic        freeze,
  output logic [15:0] data,
  output logic        msg_full,
  output logic        overflow,
  output logic        err_flag
);
  localparam int AW = $clog2(MSG_NIBBLES);
  localparam int CW = AW + 1;
  localparam int TW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(SCROLL_DIV - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(MSG_NIBBLES);

  typedef enum logic [1:0] {EMPTY, SCROLL, ERROR} state_t;

  state_t        state_q, state_d;
  logic [3:0]    mem_q [MSG_NIBBLES];
  logic [3:0]    mem_d [MSG_NIBBLES];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [15:0]   data_q, data_d;
  logic          overflow_q, overflow_d;
  logic          err_q, err_d;
`ifdef LED_SCROLL_PINGPONG_EN
  logic          dir_back_q, dir_back_d;
`endif
  logic          rx_good, rx_bad, do_write, step;

  // Message-relative index: the window wraps inside the written part of the store.
  function automatic logic [AW-1:0] win_idx(input logic [AW-1:0] rd, input int k,
                                            input logic [CW-1:0] cnt);
    logic [CW-1:0] sum;
    sum = {1'b0, rd} + CW'(k);
    if (sum >= cnt) sum = sum - cnt;
    return sum[AW-1:0];
  endfunction

  assign msg_full = (count_q == FULL_CNT);
  assign rx_good  = rx_valid & ~rx_perror & ~rx_ferror;
  assign rx_bad   = rx_valid & (rx_perror | rx_ferror);
  assign do_write = rx_good & ~msg_full & (state_q != ERROR);
  assign step     = (state_q == SCROLL) & ~freeze & (tick_q == TICK_MAX);

  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tick_d     = tick_q;
    overflow_d = overflow_q;
    err_d      = err_q;
`ifdef LED_SCROLL_PINGPONG_EN
    dir_back_d = dir_back_q;
`endif

    // Window is taken from the pre-edge state, giving one cycle of latency on data.
    data_d = 16'h0000;
    if (state_q == ERROR) begin
      data_d = 16'hEEEE;
    end else begin
      for (int k = 0; k < 4; k++) begin
        data_d[15-4*k -: 4] = mem_q[(state_q == SCROLL) ? win_idx(rd_ptr_q, k, count_q) : AW'(k)];
      end
    end

    if (state_q == EMPTY) begin
      tick_d   = '0;
      rd_ptr_d = '0;
    end else if (state_q == SCROLL && !freeze) begin
      if (step) begin
        tick_d = '0;
`ifdef LED_SCROLL_PINGPONG_EN
        if (!dir_back_q) begin
          if ({1'b0, rd_ptr_q} >= count_q - CW'(4)) begin
            dir_back_d = 1'b1;
            if (rd_ptr_q != '0) rd_ptr_d = rd_ptr_q - AW'(1);
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end else begin
          if (rd_ptr_q == '0) begin
            dir_back_d = 1'b0;
            if (count_q > CW'(4)) rd_ptr_d = AW'(1);
          end else begin
            rd_ptr_d = rd_ptr_q - AW'(1);
          end
        end
`else
        rd_ptr_d = (({1'b0, rd_ptr_q} + CW'(1)) == count_q) ? '0 : rd_ptr_q + AW'(1);
`endif
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end

    if (do_write) begin
      mem_d[wr_ptr_q]          = rx_data[7:4];
      mem_d[wr_ptr_q + AW'(1)] = rx_data[3:0];
      wr_ptr_d = wr_ptr_q + AW'(2);
      count_d  = count_q + CW'(2);
    end
    if (rx_good && msg_full && state_q != ERROR) overflow_d = 1'b1;

    if (rx_bad) begin
      state_d = ERROR;
      err_d   = 1'b1;
    end else if (state_q == EMPTY && count_d >= CW'(4)) begin
      state_d = SCROLL;
    end

    // Clear wins over any same-cycle byte, error or scroll step.
    if (clear) begin
      state_d = EMPTY;
      for (int i = 0; i < MSG_NIBBLES; i++) mem_d[i] = 4'h0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      tick_d     = '0;
      data_d     = 16'h0000;
      overflow_d = 1'b0;
      err_d      = 1'b0;
`ifdef LED_SCROLL_PINGPONG_EN
      dir_back_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      for (int i = 0; i < MSG_NIBBLES; i++) mem_q[i] <= 4'h0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tick_q     <= '0;
      data_q     <= 16'h0000;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
`ifdef LED_SCROLL_PINGPONG_EN
      dir_back_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tick_q     <= tick_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
`ifdef LED_SCROLL_PINGPONG_EN
      dir_back_q <= dir_back_d;
`endif
    end
  end

  assign data     = data_q;
  assign overflow = overflow_q;
  assign err_flag = err_q;

endmodule

// File: tb/tb_led_message_scroller.sv
// tb/tb_led_message_scroller.sv - scoreboard bench for led_message_scroller (SCROLL_DIV=4, 16 nibbles)
module tb_led_message_scroller;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_perror, rx_ferror, clear, freeze;
  logic [15:0] data;
  logic        msg_full, overflow, err_flag;

  always #5 clk = ~clk;

  led_message_scroller #(.MSG_NIBBLES(16), .SCROLL_DIV(4)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_perror(rx_perror), .rx_ferror(rx_ferror), .clear(clear), .freeze(freeze),
    .data(data), .msg_full(msg_full), .overflow(overflow), .err_flag(err_flag)
  );

  string       name_q[$];
  logic [18:0] exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        e_full, e_ovf, e_err;

  task automatic chk(input string nm, input logic [15:0] d);
    name_q.push_back(nm);
    exp_q.push_back({d, e_full, e_ovf, e_err});
  endtask

  // Monitor: every queued expectation is compared at the next falling edge.
  initial begin
    string       nm;
    logic [18:0] e, a;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        nm = name_q.pop_front();
        e  = exp_q.pop_front();
        a  = {data, msg_full, overflow, err_flag};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL %s: got data=%h full=%b ovf=%b err=%b, want data=%h full=%b ovf=%b err=%b",
                   nm, a[18:3], a[2], a[1], a[0], e[18:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic pe, input logic fe);
    rx_data = b; rx_valid = 1'b1; rx_perror = pe; rx_ferror = fe;
    step(1);
    rx_valid = 1'b0; rx_perror = 1'b0; rx_ferror = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    e_full = 1'b0; e_ovf = 1'b0; e_err = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  load8[8];
    logic [15:0] seq[5];
    load8 = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
`ifdef LED_SCROLL_PINGPONG_EN
    seq = '{16'h3456, 16'h2345, 16'h1234, 16'h2345, 16'h3456};
`else
    seq = '{16'h3456, 16'h4561, 16'h5612, 16'h6123, 16'h1234};
`endif
    reset = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_perror = 1'b0; rx_ferror = 1'b0;
    clear = 1'b0; freeze = 1'b0;
    e_full = 1'b0; e_ovf = 1'b0; e_err = 1'b0;
    step(2);
    chk("reset_state", 16'h0000);
    reset = 1'b1;
    step(1);

    // Basic wrap-around scroll over four nibbles.
    send(8'h12, 1'b0, 1'b0);
    send(8'h34, 1'b0, 1'b0);
    step(1); chk("t1_first", 16'h1234);
    step(3); chk("t1_hold", 16'h1234);
    step(1); chk("t1_s1", 16'h2341);
    step(4); chk("t1_s2", 16'h3412);
    step(4); chk("t1_s3", 16'h4123);
    step(4); chk("t1_s4", 16'h1234);

    // Fewer than four nibbles: no scrolling, unwritten digits read 0.
    do_clear(); chk("t2_clear", 16'h0000);
    send(8'hAB, 1'b0, 1'b0);
    step(1); chk("t2_ab", 16'hAB00);
    step(20); chk("t2_noscroll", 16'hAB00);

    // Fill, overflow, and wrap of the window inside a full store.
    do_clear();
    freeze = 1'b1;
    for (int i = 0; i < 8; i++) send(load8[i], 1'b0, 1'b0);
    e_full = 1'b1;
    chk("t3_full", 16'h0123);
    send(8'hFF, 1'b0, 1'b0);
    e_ovf = 1'b1;
    chk("t3_ovf", 16'h0123);
    step(1); chk("t3_ovf_data", 16'h0123);
    freeze = 1'b0;
    step(61); chk("t3_rd15_wrap", 16'hF012);
    step(4); chk("t3_rd0", 16'h0123);

    // Errored byte mid-scroll, later bytes ignored, clear recovers.
    do_clear(); chk("t4_clear", 16'h0000);
    for (int i = 1; i <= 7; i++) send(8'(i * 16), 1'b0, 1'b0);
    step(3);
    send(8'h77, 1'b1, 1'b0);
    e_err = 1'b1;
    step(1); chk("t4_eeee", 16'hEEEE);
    send(8'h11, 1'b0, 1'b0); chk("t4_good_ignored", 16'hEEEE);
    send(8'h22, 1'b0, 1'b1); chk("t4_ferr", 16'hEEEE);
    do_clear(); chk("t4_after_clear", 16'h0000);
    step(3); chk("t4_empty", 16'h0000);

    // Freeze holds the tick count; the step lands after the remaining ticks.
    send(8'h12, 1'b0, 1'b0);
    send(8'h34, 1'b0, 1'b0);
    step(2);
    freeze = 1'b1;
    step(12); chk("t5_frozen", 16'h1234);
    freeze = 1'b0;
    step(2); chk("t5_pre_step", 16'h1234);
    step(1); chk("t5_step", 16'h2341);
    rx_data = 8'h99; rx_valid = 1'b1; clear = 1'b1;
    step(1);
    rx_valid = 1'b0; clear = 1'b0;
    e_full = 1'b0; e_ovf = 1'b0; e_err = 1'b0;
    chk("t5_clear_rx", 16'h0000);
    step(1); chk("t5_rx_dropped", 16'h0000);
    step(8); chk("t5_rx_dropped2", 16'h0000);

    // Six-nibble message: wrap modulo a non-power-of-two count (or bounce).
    send(8'h12, 1'b0, 1'b0);
    send(8'h34, 1'b0, 1'b0);
    send(8'h56, 1'b0, 1'b0);
    step(1); chk("t6_first", 16'h1234);
    step(3); chk("t6_s1", 16'h2345);
    for (int i = 0; i < 5; i++) begin
      step(4); chk($sformatf("t6_s%0d", i + 2), seq[i]);
    end
    step(2);
    reset = 1'b0;
    chk("t6_async_reset", 16'h0000);
    step(1);
    reset = 1'b1;
    step(3); chk("t6_after_reset", 16'h0000);

    step(2);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
